// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared definitions for the load-use hazard logic.
//   REG_IDX_W : width of a register index in the pipeline register file.
//   reg_idx_t : register index type. Index ports default to this width.
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage : hazard_pkg

// File: rtl/reg_match.sv
// -----------------------------------------------------------------------------
// reg_match
//   Equality compare of two register indices. There is no special case for
//   index 0, so a match on r0 counts like any other index.
//   Parameters : WIDTH - index width
//   Ports      : a, b  - indices to compare
//                eq    - 1 when a == b (combinational)
// -----------------------------------------------------------------------------
module reg_match
  import hazard_pkg::*;
#(
  parameter int WIDTH = REG_IDX_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  assign eq = (a == b);

endmodule : reg_match

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating event counter with synchronous active-high reset.
//   It counts one on each rising edge where inc is high. Once it reaches
//   all-ones it stays there instead of wrapping.
//   Parameters : WIDTH - counter width
//   Ports      : clk   - clock, rising edge
//                rst   - synchronous reset; clears the count to 0
//                inc   - count this cycle
//                count - current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             at_max;

  assign at_max = &count_reg;

  always_comb begin
    count_next = count_reg;
    if (inc && !at_max) begin
      count_next = count_reg + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule : sat_counter

// File: rtl/lw_hazard_unit.sv
// -----------------------------------------------------------------------------
// lw_hazard_unit
//   Load-use hazard detector for a 5-stage pipeline. When the Execute-stage
//   instruction is a load and its destination register is a source of the
//   Decode-stage instruction, the unit stalls Fetch and Decode and flushes
//   Execute for one cycle. All hazard outputs are combinational, with zero
//   latency. rst forces them low right away.
//
//   Optional feature: macro LW_HAZARD_PERF_CNT_EN adds the CNT_WIDTH
//   parameter, the stall_count port and a saturating stall-cycle counter.
//   Without the macro the unit is purely combinational.
//
//   Parameters : WIDTH      - register index width (default 5)
//                CNT_WIDTH  - stall counter width (macro only, default 32)
//   Ports      : clk        - clock; used only by the stall counter
//                rst        - synchronous active-high reset; also gates the
//                             hazard outputs combinationally
//                RegS1D     - Decode source register 1
//                RegS2D     - Decode source register 2
//                WriteRegE  - Execute destination register
//                MeMtoRegE  - Execute instruction is a load
//                lwstall    - load-use hazard detected
//                StallF     - hold PC / Fetch register
//                StallD     - hold Decode register
//                FlushE     - bubble into Execute
//                stall_count- stall cycles since reset (macro only)
// -----------------------------------------------------------------------------
module lw_hazard_unit
  import hazard_pkg::*;
#(
  parameter int WIDTH = REG_IDX_W
`ifdef LW_HAZARD_PERF_CNT_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     RegS1D,
  input  logic [WIDTH-1:0]     RegS2D,
  input  logic [WIDTH-1:0]     WriteRegE,
  input  logic                 MeMtoRegE,
  output logic                 lwstall,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushE
`ifdef LW_HAZARD_PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0] stall_count
`endif
);

  logic s1_match;
  logic s2_match;

  reg_match #(
    .WIDTH (WIDTH)
  ) u_match_s1 (
    .a  (RegS1D),
    .b  (WriteRegE),
    .eq (s1_match)
  );

  reg_match #(
    .WIDTH (WIDTH)
  ) u_match_s2 (
    .a  (RegS2D),
    .b  (WriteRegE),
    .eq (s2_match)
  );

  // A match on both sources is still a single stall. The OR merges them.
  assign lwstall = ~rst & MeMtoRegE & (s1_match | s2_match);
  assign StallF  = lwstall;
  assign StallD  = lwstall;
  assign FlushE  = lwstall;

`ifdef LW_HAZARD_PERF_CNT_EN
  // lwstall is already low during rst, so the counter holds only by its own
  // synchronous clear.
  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lwstall),
    .count (stall_count)
  );
`else
  // Without the counter the clock has no load.
  logic unused_clk;
  assign unused_clk = clk;
`endif

endmodule : lw_hazard_unit

// File: tb/tb_lw_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_lw_hazard_unit
//   Self-checking bench for lw_hazard_unit. It applies a table of directed
//   vectors, then hand-written reset/counter sequences, then random stimulus
//   that is compared against a rule-level reference model. If
//   LW_HAZARD_PERF_CNT_EN is defined, it also checks the stall counters:
//   a 32-bit counter and a 2-bit counter that should saturate.
// -----------------------------------------------------------------------------
module tb_lw_hazard_unit;
  import hazard_pkg::*;

  logic     clk;
  logic     rst;
  reg_idx_t s1;
  reg_idx_t s2;
  reg_idx_t we;
  logic     mem;
  logic     lwstall;
  logic     stall_f;
  logic     stall_d;
  logic     flush_e;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LW_HAZARD_PERF_CNT_EN
  logic [31:0] stall_count;
  logic [1:0]  small_count;
  logic        sm_lwstall;
  logic        sm_stall_f;
  logic        sm_stall_d;
  logic        sm_flush_e;
  longint      model_cnt;
  int          model_small;

  lw_hazard_unit #(
    .WIDTH     (REG_IDX_W),
    .CNT_WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RegS1D      (s1),
    .RegS2D      (s2),
    .WriteRegE   (we),
    .MeMtoRegE   (mem),
    .lwstall     (lwstall),
    .StallF      (stall_f),
    .StallD      (stall_d),
    .FlushE      (flush_e),
    .stall_count (stall_count)
  );

  lw_hazard_unit #(
    .WIDTH     (REG_IDX_W),
    .CNT_WIDTH (2)
  ) dut_small (
    .clk         (clk),
    .rst         (rst),
    .RegS1D      (s1),
    .RegS2D      (s2),
    .WriteRegE   (we),
    .MeMtoRegE   (mem),
    .lwstall     (sm_lwstall),
    .StallF      (sm_stall_f),
    .StallD      (sm_stall_d),
    .FlushE      (sm_flush_e),
    .stall_count (small_count)
  );
`else
  lw_hazard_unit #(
    .WIDTH (REG_IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RegS1D    (s1),
    .RegS2D    (s2),
    .WriteRegE (we),
    .MeMtoRegE (mem),
    .lwstall   (lwstall),
    .StallF    (stall_f),
    .StallD    (stall_d),
    .FlushE    (flush_e)
  );
`endif

  typedef struct {
    string    name;
    logic     rst;
    reg_idx_t s1;
    reg_idx_t s2;
    reg_idx_t we;
    logic     mem;
    logic     exp;
  } vec_t;

  vec_t vecs[10];

  // Reference rule: the Execute load writes a register that Decode reads.
  function automatic logic ref_stall(logic r, reg_idx_t a, reg_idx_t b,
                                     reg_idx_t w, logic m);
    return !r && m && ((a == w) || (b == w));
  endfunction

  // Compares the counters against the model at a falling edge, then drives
  // new inputs, checks all four hazard outputs 1 ns later, and advances the
  // counter model for the coming rising edge.
  task automatic step(input string name, input logic r, input reg_idx_t a,
                      input reg_idx_t b, input reg_idx_t w, input logic m,
                      input logic exp);
    logic [3:0] got;
    @(negedge clk);
`ifdef LW_HAZARD_PERF_CNT_EN
    checks++;
    if (stall_count !== model_cnt[31:0]) begin
      errors++;
      $display("FAIL %s/cnt got=%0d want=%0d", name, stall_count, model_cnt);
    end
    checks++;
    if (small_count !== model_small[1:0]) begin
      errors++;
      $display("FAIL %s/cnt2 got=%0d want=%0d", name, small_count, model_small);
    end
`endif
    rst = r; s1 = a; s2 = b; we = w; mem = m;
    #1;
    got = {lwstall, stall_f, stall_d, flush_e};
    checks++;
    if (got !== {4{exp}}) begin
      errors++;
      $display("FAIL %s rst=%0b s1=%0d s2=%0d we=%0d mem=%0b {lw,F,D,E} got=%b want=%b",
               name, r, a, b, w, m, got, {4{exp}});
    end else begin
      $display("ok   %s rst=%0b s1=%0d s2=%0d we=%0d mem=%0b lwstall=%0b",
               name, r, a, b, w, m, lwstall);
    end
`ifdef LW_HAZARD_PERF_CNT_EN
    if (r) begin
      model_cnt   = 0;
      model_small = 0;
    end else if (ref_stall(r, a, b, w, m)) begin
      if (model_cnt < 64'hFFFF_FFFF) model_cnt = model_cnt + 1;
      if (model_small < 3) model_small = model_small + 1;
    end
`endif
  endtask

`ifdef LW_HAZARD_PERF_CNT_EN
  task automatic expect_cnt(input string name, input longint want,
                            input int want_small);
    checks++;
    if (stall_count !== want[31:0]) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, stall_count, want);
    end
    checks++;
    if (small_count !== want_small[1:0]) begin
      errors++;
      $display("FAIL %s/2bit got=%0d want=%0d", name, small_count, want_small);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; s1 = '0; s2 = '0; we = '0; mem = 1'b0;
`ifdef LW_HAZARD_PERF_CNT_EN
    // The first rising edge (t=5) occurs with rst high.
    model_cnt   = 0;
    model_small = 0;
`endif

    vecs[0] = '{"reset_gates",   1'b1, 5'd1,  5'd2,  5'd1,  1'b1, 1'b0};
    vecs[1] = '{"noload_we1",    1'b0, 5'd1,  5'd2,  5'd1,  1'b0, 1'b0};
    vecs[2] = '{"noload_we2",    1'b0, 5'd1,  5'd2,  5'd2,  1'b0, 1'b0};
    vecs[3] = '{"load_s1",       1'b0, 5'd1,  5'd2,  5'd1,  1'b1, 1'b1};
    vecs[4] = '{"load_s2",       1'b0, 5'd1,  5'd2,  5'd2,  1'b1, 1'b1};
    vecs[5] = '{"load_both",     1'b0, 5'd1,  5'd1,  5'd1,  1'b1, 1'b1};
    vecs[6] = '{"load_nomatch",  1'b0, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0};
    vecs[7] = '{"load_r0",       1'b0, 5'd0,  5'd1,  5'd0,  1'b1, 1'b1};
    vecs[8] = '{"load_r31",      1'b0, 5'd4,  5'd31, 5'd31, 1'b1, 1'b1};
    vecs[9] = '{"reset_r0",      1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].s1, vecs[i].s2, vecs[i].we,
           vecs[i].mem, vecs[i].exp);
    end

    // Reset during a stall drops the outputs at once. Releasing it restores them.
    step("pre_stall",   1'b0, 5'd7, 5'd8, 5'd7, 1'b1, 1'b1);
    step("mid_reset",   1'b1, 5'd7, 5'd8, 5'd7, 1'b1, 1'b0);
    step("post_reset",  1'b0, 5'd7, 5'd8, 5'd7, 1'b1, 1'b1);

`ifdef LW_HAZARD_PERF_CNT_EN
    // Three hazard edges, then a reset edge, then five hazard edges.
    step("cnt_rst",     1'b1, 5'd1, 5'd2, 5'd1, 1'b1, 1'b0);
    step("cnt_h1",      1'b0, 5'd1, 5'd2, 5'd1, 1'b1, 1'b1);
    step("cnt_h2",      1'b0, 5'd1, 5'd2, 5'd2, 1'b1, 1'b1);
    step("cnt_h3",      1'b0, 5'd1, 5'd2, 5'd1, 1'b1, 1'b1);
    step("cnt_rst2",    1'b1, 5'd1, 5'd2, 5'd1, 1'b1, 1'b0);
    expect_cnt("cnt_after3", 64'd3, 3);
    step("cnt_idle",    1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    expect_cnt("cnt_cleared", 64'd0, 0);
    for (int i = 0; i < 5; i++) begin
      step("cnt_sat", 1'b0, 5'd5, 5'd6, 5'd6, 1'b1, 1'b1);
    end
    step("cnt_hold",    1'b0, 5'd5, 5'd6, 5'd6, 1'b0, 1'b0);
    expect_cnt("cnt_after5", 64'd5, 3);
    step("cnt_hold2",   1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
    expect_cnt("cnt_held", 64'd5, 3);
`endif

    // Random stimulus. Indices come from a narrow range so that matches are
    // common, and reset is asserted now and then.
    for (int i = 0; i < 300; i++) begin
      logic     r;
      logic     m;
      reg_idx_t a;
      reg_idx_t b;
      reg_idx_t w;
      r = ($urandom_range(0, 15) == 0);
      m = $urandom_range(0, 3) != 0;
      a = reg_idx_t'($urandom_range(0, 3));
      b = reg_idx_t'($urandom_range(0, 3));
      w = (i % 50 == 7) ? reg_idx_t'($urandom_range(0, 31))
                        : reg_idx_t'($urandom_range(0, 3));
      step("rand", r, a, b, w, m, ref_stall(r, a, b, w, m));
    end
    // A final falling-edge visit compares the counters after the last edge.
    step("final", 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_lw_hazard_unit
